// File: rtl/wb_master_pkg.sv
// -----------------------------------------------------------------------------
// wb_master_pkg
// Shared definitions for the Wishbone single-beat master core:
//   - wb_state_e : master FSM state encoding (IDLE, ACTIVE)
//   - CTI_*      : Wishbone cycle-type identifier codes
//   - BTE_*      : Wishbone burst-type extension codes
// The core forwards CTI/BTE untouched; the constants exist so that users and
// benches can name the codes rather than spell out raw bit patterns.
// -----------------------------------------------------------------------------
package wb_master_pkg;

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } wb_state_e;

  localparam logic [2:0] CTI_CLASSIC = 3'b000;
  localparam logic [2:0] CTI_CONST   = 3'b001;
  localparam logic [2:0] CTI_INCR    = 3'b010;
  localparam logic [2:0] CTI_END     = 3'b111;

  localparam logic [1:0] BTE_LINEAR  = 2'b00;
  localparam logic [1:0] BTE_WRAP4   = 2'b01;
  localparam logic [1:0] BTE_WRAP8   = 2'b10;
  localparam logic [1:0] BTE_WRAP16  = 2'b11;

endpackage : wb_master_pkg

// File: rtl/wb_master_core.sv
// -----------------------------------------------------------------------------
// wb_master_core
// Turns one command (valid/ready handshake) into exactly one Wishbone beat and
// reports completion with a single-cycle response pulse.
//
// Ports
//   clk, rstn                : clock (rising edge), synchronous active-low reset
//   req_valid / req_ready    : command handshake, accepted when both high
//   req_adr, req_cti, req_bte,
//   req_sel, req_we, req_wdata : command fields
//   rsp_valid                : one-cycle completion pulse
//   rsp_rdata                : read data captured at termination of a read
//   rsp_err                  : ERR sampled at termination
//   ADR, CTI, BTE, DAT_W, SEL,
//   CYC, STB, WE             : registered Wishbone master outputs
//   DAT_R, ACK, ERR          : Wishbone slave response inputs
// -----------------------------------------------------------------------------
module wb_master_core
  import wb_master_pkg::*;
#(
  parameter int WB_ADDR_WIDTH = 32,
  parameter int WB_DATA_WIDTH = 32
) (
  input  logic                       clk,
  input  logic                       rstn,

  input  logic                       req_valid,
  output logic                       req_ready,
  input  logic [WB_ADDR_WIDTH-1:0]   req_adr,
  input  logic [2:0]                 req_cti,
  input  logic [1:0]                 req_bte,
  input  logic [WB_DATA_WIDTH/8-1:0] req_sel,
  input  logic                       req_we,
  input  logic [WB_DATA_WIDTH-1:0]   req_wdata,

  output logic                       rsp_valid,
  output logic [WB_DATA_WIDTH-1:0]   rsp_rdata,
  output logic                       rsp_err,

  output logic [WB_ADDR_WIDTH-1:0]   ADR,
  output logic [2:0]                 CTI,
  output logic [1:0]                 BTE,
  output logic [WB_DATA_WIDTH-1:0]   DAT_W,
  output logic [WB_DATA_WIDTH/8-1:0] SEL,
  output logic                       CYC,
  output logic                       STB,
  output logic                       WE,

  input  logic [WB_DATA_WIDTH-1:0]   DAT_R,
  input  logic                       ACK,
  input  logic                       ERR
);

  wb_state_e state_r;

  // A one-beat master needs nothing but the handshake and the termination
  // condition, so the whole datapath lives in the FSM register block.
  //
  // req_ready is kept as a register that already encodes "ready flag set AND
  // state is IDLE": it is cleared by reset, so it stays low for the first
  // cycle after rstn rises, and is rewritten every cycle with the value the
  // flag/state pair will have after this edge.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_r   <= IDLE;
      req_ready <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_err   <= 1'b0;
      rsp_rdata <= {WB_DATA_WIDTH{1'b0}};
      ADR       <= {WB_ADDR_WIDTH{1'b0}};
      CTI       <= 3'b000;
      BTE       <= 2'b00;
      DAT_W     <= {WB_DATA_WIDTH{1'b0}};
      SEL       <= {(WB_DATA_WIDTH/8){1'b0}};
      CYC       <= 1'b0;
      STB       <= 1'b0;
      WE        <= 1'b0;
    end else begin
      // Response pulse lasts exactly one cycle unless re-armed below.
      rsp_valid <= 1'b0;

      case (state_r)
        IDLE: begin
          if (req_valid && req_ready) begin
            state_r   <= ACTIVE;
            req_ready <= 1'b0;
            ADR       <= req_adr;
            CTI       <= req_cti;
            BTE       <= req_bte;
            SEL       <= req_sel;
            WE        <= req_we;
            // Reads drive a clean zero data bus rather than stale data.
            DAT_W     <= req_we ? req_wdata : {WB_DATA_WIDTH{1'b0}};
            CYC       <= 1'b1;
            STB       <= 1'b1;
          end else begin
            // Wishbone outputs hold; the ready flag becomes set here on the
            // first edge after reset.
            req_ready <= 1'b1;
          end
        end

        ACTIVE: begin
          if (ACK || ERR) begin
            state_r   <= IDLE;
            // Ready again from m+1, so the next accept is at edge m+1 at the
            // earliest and CYC is low for at least one cycle in between.
            req_ready <= 1'b1;
            rsp_valid <= 1'b1;
            // ERR wins when both are asserted.
            rsp_err   <= ERR;
            if (!WE) begin
              rsp_rdata <= DAT_R;
            end else begin
              rsp_rdata <= rsp_rdata;
            end
            // WE and DAT_W intentionally keep their last values.
            ADR       <= {WB_ADDR_WIDTH{1'b0}};
            CTI       <= 3'b000;
            BTE       <= 2'b00;
            SEL       <= {(WB_DATA_WIDTH/8){1'b0}};
            CYC       <= 1'b0;
            STB       <= 1'b0;
          end else begin
            // No timeout: wait for the slave indefinitely, outputs stable.
            req_ready <= 1'b0;
          end
        end

        default: begin
          state_r   <= IDLE;
          req_ready <= 1'b0;
          CYC       <= 1'b0;
          STB       <= 1'b0;
        end
      endcase
    end
  end

endmodule : wb_master_core

// File: tb/tb_wb_master_core.sv
// -----------------------------------------------------------------------------
// tb_wb_master_core
// Directed bench for wb_master_core. The stimulus process pushes the expected
// response of every issued command into a queue; a monitor pops and compares
// whenever rsp_valid is seen. Wishbone-side behaviour is checked inline.
// -----------------------------------------------------------------------------
module tb_wb_master_core;
  import wb_master_pkg::*;

  localparam int AW = 32;
  localparam int DW = 32;

  typedef struct packed {
    logic [DW-1:0] rdata;
    logic          err;
  } exp_rsp_t;

  logic            clk;
  logic            rstn;
  logic            req_valid;
  logic            req_ready;
  logic [AW-1:0]   req_adr;
  logic [2:0]      req_cti;
  logic [1:0]      req_bte;
  logic [DW/8-1:0] req_sel;
  logic            req_we;
  logic [DW-1:0]   req_wdata;
  logic            rsp_valid;
  logic [DW-1:0]   rsp_rdata;
  logic            rsp_err;
  logic [AW-1:0]   ADR;
  logic [2:0]      CTI;
  logic [1:0]      BTE;
  logic [DW-1:0]   DAT_W;
  logic [DW/8-1:0] SEL;
  logic            CYC;
  logic            STB;
  logic            WE;
  logic [DW-1:0]   DAT_R;
  logic            ACK;
  logic            ERR;

  int n_vec = 0;
  int n_err = 0;
  exp_rsp_t exp_q[$];

  wb_master_core #(.WB_ADDR_WIDTH(AW), .WB_DATA_WIDTH(DW)) dut (
    .clk(clk), .rstn(rstn),
    .req_valid(req_valid), .req_ready(req_ready), .req_adr(req_adr),
    .req_cti(req_cti), .req_bte(req_bte), .req_sel(req_sel),
    .req_we(req_we), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .ADR(ADR), .CTI(CTI), .BTE(BTE), .DAT_W(DAT_W), .SEL(SEL),
    .CYC(CYC), .STB(STB), .WE(WE),
    .DAT_R(DAT_R), .ACK(ACK), .ERR(ERR)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input logic v, input logic we, input logic [AW-1:0] adr,
                         input logic [DW-1:0] wd, input logic [3:0] sel,
                         input logic [2:0] cti, input logic [1:0] bte);
    req_valid = v; req_we = we; req_adr = adr; req_wdata = wd;
    req_sel = sel; req_cti = cti; req_bte = bte;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_cyc"},   64'(CYC), 64'd0);
    chk({tag, "_stb"},   64'(STB), 64'd0);
    chk({tag, "_adr"},   64'(ADR), 64'd0);
    chk({tag, "_datw"},  64'(DAT_W), 64'd0);
    chk({tag, "_we"},    64'(WE), 64'd0);
    chk({tag, "_sel"},   64'(SEL), 64'd0);
    chk({tag, "_cti"},   64'(CTI), 64'd0);
    chk({tag, "_bte"},   64'(BTE), 64'd0);
    chk({tag, "_rspv"},  64'(rsp_valid), 64'd0);
    chk({tag, "_rspe"},  64'(rsp_err), 64'd0);
    chk({tag, "_rdata"}, 64'(rsp_rdata), 64'd0);
    chk({tag, "_ready"}, 64'(req_ready), 64'd0);
  endtask

  // Monitor: every response pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (rsp_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_rsp", 64'd1, 64'd0);
      end else begin
        exp_rsp_t e;
        e = exp_q.pop_front();
        chk("rsp_rdata", 64'(rsp_rdata), 64'(e.rdata));
        chk("rsp_err",   64'(rsp_err),   64'(e.err));
      end
    end
  end

  initial begin
    int cyc_cnt;
    rstn = 1'b0;
    set_req(1'b0, 1'b0, 32'h0, 32'h0, 4'h0, CTI_CLASSIC, BTE_LINEAR);
    DAT_R = 32'h0; ACK = 1'b0; ERR = 1'b0;

    // Reset state
    tick(); tick();
    chk_all_zero("reset");
    rstn = 1'b1;
    chk("ready_first_cycle", 64'(req_ready), 64'd0);
    tick();
    chk("ready_after_reset", 64'(req_ready), 64'd1);

    // Write, ACK after two wait cycles
    set_req(1'b1, 1'b1, 32'h0000_1000, 32'hDEAD_BEEF, 4'hF, CTI_CLASSIC, BTE_LINEAR);
    exp_q.push_back('{rdata: 32'h0, err: 1'b0});
    tick();
    req_valid = 1'b0;
    chk("wr_adr",   64'(ADR), 64'h1000);
    chk("wr_datw",  64'(DAT_W), 64'hDEAD_BEEF);
    chk("wr_we",    64'(WE), 64'd1);
    chk("wr_sel",   64'(SEL), 64'hF);
    chk("wr_ready", 64'(req_ready), 64'd0);
    cyc_cnt = 0;
    for (int i = 0; i < 6; i++) begin
      if (CYC === 1'b1 && STB === 1'b1) cyc_cnt++;
      ACK = (i == 2) ? 1'b1 : 1'b0;
      tick();
    end
    ACK = 1'b0;
    chk("wr_cyc_cycles", 64'(cyc_cnt), 64'd3);
    chk("wr_we_hold",   64'(WE), 64'd1);
    chk("wr_datw_hold", 64'(DAT_W), 64'hDEAD_BEEF);
    chk("wr_adr_clr",   64'(ADR), 64'h0);

    // Read with zero-wait ACK; CTI/BTE passed through
    set_req(1'b1, 1'b0, 32'h0000_2004, 32'hFFFF_FFFF, 4'hF, CTI_INCR, BTE_WRAP4);
    exp_q.push_back('{rdata: 32'h1234_5678, err: 1'b0});
    tick();
    req_valid = 1'b0;
    chk("rd_adr",  64'(ADR), 64'h2004);
    chk("rd_datw", 64'(DAT_W), 64'h0);
    chk("rd_we",   64'(WE), 64'd0);
    chk("rd_cti",  64'(CTI), 64'(CTI_INCR));
    chk("rd_bte",  64'(BTE), 64'(BTE_WRAP4));
    chk("rd_cyc",  64'(CYC), 64'd1);
    DAT_R = 32'h1234_5678; ACK = 1'b1;
    tick();
    ACK = 1'b0; DAT_R = 32'h5555_5555;
    chk("rd_cyc_drop", 64'(CYC), 64'd0);
    chk("rd_cti_clr",  64'(CTI), 64'd0);

    // Read terminated by ERR
    set_req(1'b1, 1'b0, 32'h0000_2008, 32'h0, 4'h3, CTI_END, BTE_WRAP16);
    exp_q.push_back('{rdata: 32'hCAFE_F00D, err: 1'b1});
    tick();
    req_valid = 1'b0;
    tick();
    chk("err_cyc_wait", 64'(CYC), 64'd1);
    DAT_R = 32'hCAFE_F00D; ERR = 1'b1;
    tick();
    ERR = 1'b0;
    chk("err_cyc_drop", 64'(CYC), 64'd0);
    chk("err_rspv",     64'(rsp_valid), 64'd1);
    tick();
    chk("err_rspv_once", 64'(rsp_valid), 64'd0);

    // Back-to-back with ACK held high: write A then read B
    ACK = 1'b1; DAT_R = 32'hA5A5_A5A5;
    set_req(1'b1, 1'b1, 32'h0000_3000, 32'h1111_1111, 4'hF, CTI_CONST, BTE_WRAP8);
    exp_q.push_back('{rdata: 32'hCAFE_F00D, err: 1'b0});
    exp_q.push_back('{rdata: 32'hA5A5_A5A5, err: 1'b0});
    tick();
    chk("b2b_a_cyc",   64'(CYC), 64'd1);
    chk("b2b_a_adr",   64'(ADR), 64'h3000);
    chk("b2b_a_ready", 64'(req_ready), 64'd0);
    set_req(1'b1, 1'b0, 32'h0000_3008, 32'h2222_2222, 4'hC, CTI_CLASSIC, BTE_LINEAR);
    tick();
    chk("b2b_gap_cyc",   64'(CYC), 64'd0);
    chk("b2b_gap_ready", 64'(req_ready), 64'd1);
    tick();
    req_valid = 1'b0;
    chk("b2b_b_cyc",   64'(CYC), 64'd1);
    chk("b2b_b_adr",   64'(ADR), 64'h3008);
    chk("b2b_b_ready", 64'(req_ready), 64'd0);
    tick();
    chk("b2b_b_done", 64'(CYC), 64'd0);
    ACK = 1'b0;

    // ACK and ERR together on a read: error reported, data still captured
    set_req(1'b1, 1'b0, 32'h0000_5000, 32'h0, 4'hF, CTI_CLASSIC, BTE_LINEAR);
    exp_q.push_back('{rdata: 32'h0BAD_BEEF, err: 1'b1});
    tick();
    req_valid = 1'b0;
    DAT_R = 32'h0BAD_BEEF; ACK = 1'b1; ERR = 1'b1;
    tick();
    ACK = 1'b0; ERR = 1'b0;
    tick();

    // Reset while ACTIVE: request inputs ignored, no timeout, transfer aborted
    set_req(1'b1, 1'b1, 32'h0000_4000, 32'h7777_7777, 4'h1, CTI_CLASSIC, BTE_LINEAR);
    tick();
    set_req(1'b1, 1'b0, 32'h0000_9999, 32'h0, 4'h8, CTI_END, BTE_WRAP16);
    for (int i = 0; i < 5; i++) tick();
    chk("act_cyc_hold", 64'(CYC), 64'd1);
    chk("act_adr_hold", 64'(ADR), 64'h4000);
    chk("act_we_hold",  64'(WE), 64'd1);
    req_valid = 1'b0;
    rstn = 1'b0;
    tick();
    chk_all_zero("abort");
    rstn = 1'b1;
    chk("abort_ready_first", 64'(req_ready), 64'd0);
    tick();
    chk("abort_ready_after", 64'(req_ready), 64'd1);
    tick(); tick();

    chk("pending_rsp", 64'(exp_q.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule : tb_wb_master_core

// File: doc/wb_master_core.md
WB_MASTER_CORE -- requirements
Module: wb_master_core

Interface
REQ-001 Parameter WB_ADDR_WIDTH, default 32, address bus width in bits.
REQ-002 Parameter WB_DATA_WIDTH, default 32, data bus width in bits; multiple of 8.
REQ-003 clk  input  1  single clock; all logic on rising edge.
REQ-004 rstn  input  1  reset; synchronous, active-low.
REQ-005 req_valid  input  1  command request.
REQ-006 req_ready  output  1  command accepted when req_valid && req_ready at clk edge.
REQ-007 req_adr  input  WB_ADDR_WIDTH  address.
REQ-008 req_cti, req_bte, req_sel, req_we, req_wdata  inputs  3, 2, WB_DATA_WIDTH/8, 1, WB_DATA_WIDTH  cycle-type, burst-type, byte selects, write enable, write data.
REQ-009 rsp_valid  output  1  one-cycle completion pulse.
REQ-010 rsp_rdata  output  WB_DATA_WIDTH  captured read data.
REQ-011 rsp_err  output  1  ERR sampled at termination.
REQ-012 ADR, CTI, BTE, DAT_W, SEL, CYC, STB, WE  outputs  WB_ADDR_WIDTH, 3, 2, WB_DATA_WIDTH, WB_DATA_WIDTH/8, 1, 1, 1  Wishbone master signals, all registered.
REQ-013 DAT_R, ACK, ERR  inputs  WB_DATA_WIDTH, 1, 1  Wishbone slave response.

Function
REQ-014 FSM states: IDLE, ACTIVE.
REQ-015 A ready flag is set on the first clk edge with rstn high after reset; req_ready SHALL be 1 only when the flag is set and state is IDLE.
REQ-016 IDLE + accepted request at edge k: from k+1, CYC=STB=1, ADR/CTI/BTE/SEL/WE = request values, DAT_W = req_wdata if req_we else 0; state -> ACTIVE.
REQ-017 IDLE without accepted request: outputs hold.
REQ-018 ACTIVE: request inputs ignored; Wishbone outputs held stable until termination.
REQ-019 Termination: ACK or ERR sampled high at edge m while ACTIVE.
REQ-020 At termination: from m+1, CYC, STB, ADR, CTI, BTE, SEL = 0; WE and DAT_W retain values; state -> IDLE.
REQ-021 At termination: rsp_valid=1 for exactly cycle m+1, rsp_err = ERR sampled at m.
REQ-022 At termination of a read (WE=0): rsp_rdata = DAT_R sampled at m; write terminations leave rsp_rdata unchanged.
REQ-023 ACK and ERR both high: treated as error termination (rsp_err=1); read data still captured.
REQ-024 Next request accepted no earlier than edge m+1; CYC therefore low for at least one cycle between transfers.
REQ-025 No timeout: ACTIVE persists indefinitely without ACK/ERR.

Reset
REQ-026 rstn low at any edge: state=IDLE, ready flag=0, all Wishbone outputs=0, rsp_valid=0, rsp_err=0, rsp_rdata=0.
REQ-027 Reset while ACTIVE aborts the transfer; no rsp_valid generated for it.
REQ-028 After rstn rises, req_ready=0 for the first cycle and rises no earlier than one edge later.

Structure
REQ-029 Package wb_master_pkg SHALL hold the FSM state enum and CTI constants (CLASSIC=3'b000, CONST=3'b001, INCR=3'b010, END=3'b111) and BTE constants (LINEAR=2'b00, WRAP4/8/16=2'b01/10/11).
REQ-030 Single flat module; no sub-module.
REQ-031 CTI/BTE passed through without interpretation; one beat per request.

Verification
REQ-032 Reset then write adr=0x1000, wdata=0xDEADBEEF, sel=0xF, ACK after 2 cycles -> CYC/STB=1 three cycles, DAT_W=0xDEADBEEF, rsp_valid one cycle, rsp_err=0.
REQ-033 Read adr=0x2004, slave DAT_R=0x12345678 with ACK -> rsp_rdata=0x12345678, DAT_W=0, WE=0.
REQ-034 Read terminated by ERR=1, ACK=0 -> rsp_valid=1, rsp_err=1, CYC drops next cycle.
REQ-035 Back-to-back requests, zero-wait ACK -> CYC low exactly one cycle between transfers; req_ready low whole ACTIVE phase.
REQ-036 rstn low while ACTIVE with no ACK -> next cycle all outputs 0, no rsp_valid; req_ready=0 for the first cycle after rstn rises, then 1.
